// File: rtl/pong_video_pkg.sv
// Shared timing defaults, colour widths and the RGB565 pixel type for the Pong video path.
// Imported by pixel_tick_gen and pong_video_timer.
package pong_video_pkg;

    // 640x480@60 timing (pixels / lines)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 5;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int RED_W   = 5;
    localparam int GREEN_W = 6;
    localparam int BLUE_W  = 5;

    typedef struct packed {
        logic [RED_W-1:0]   red;
        logic [GREEN_W-1:0] green;
        logic [BLUE_W-1:0]  blue;
    } rgb565_t;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-cycle pixel enable, CLK_DIV clocks per pixel.
// The divider starts counting in the first clock after reset is released.
module pixel_tick_gen
    import pong_video_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_pixel_en
);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be in 1..16");
    end

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic       r_run;
    logic [3:0] r_div;

    // r_run keeps the count at 0 for the first clock out of reset, so the
    // enable lands on count CLK_DIV-1 and is never high while in reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run <= 1'b0;
            r_div <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + 4'd1;
            end
        end
    end

    assign o_pixel_en = r_run && (r_div == DIV_LAST);

endmodule

// File: rtl/pong_video_timer.sv
// Parametrised VGA timing generator for Pong: pixel counters, syncs, blanking and registered colour.
// Optional build macro PONG_VT_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt).
module pong_video_timer
    import pong_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic               pixel_en,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               active,
    output logic               frame_start,
    output logic               line_start,
    input  logic [RED_W-1:0]   red_in,
    input  logic [GREEN_W-1:0] green_in,
    input  logic [BLUE_W-1:0]  blue_in,
    output logic [RED_W-1:0]   red,
    output logic [GREEN_W-1:0] green,
    output logic [BLUE_W-1:0]  blue,
    output logic               hsync,
    output logic               vsync
`ifdef PONG_VT_FRAME_CNT_EN
    ,output logic [15:0]       frame_cnt
`endif
);

    localparam int H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
        $error("pong_video_timer: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
        $error("pong_video_timer: V_TOTAL exceeds 1024");
    end

    logic               w_pixel_en;
    logic               w_active;
    logic               w_hs_zone;
    logic               w_vs_zone;
    logic               w_line_start;
    rgb565_t            w_pix_in;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    rgb565_t            r_pix;
    logic               r_hsync;
    logic               r_vsync;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk      (Clock),
        .i_reset    (Reset),
        .o_pixel_en (w_pixel_en)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pixel_en) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + COORD_W'(1);
            end else begin
                r_x <= r_x + COORD_W'(1);
            end
        end
    end

    // Stage-0 decode of the pixel currently being requested from the game unit
    assign w_active     = (int'(r_x) < H_ACTIVE) && (int'(r_y) < V_ACTIVE);
    assign w_hs_zone    = (int'(r_x) >= HS_START) && (int'(r_x) < HS_END);
    assign w_vs_zone    = (int'(r_y) >= VS_START) && (int'(r_y) < VS_END);
    assign w_line_start = w_pixel_en && (r_x == '0);
    assign w_pix_in     = '{red: red_in, green: green_in, blue: blue_in};

    // Colour and syncs are captured together from the same stage-0 pixel, so they leave aligned
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pix   <= '0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else if (w_pixel_en) begin
            r_pix   <= w_active ? w_pix_in : '0;
            r_hsync <= w_hs_zone ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_vs_zone ? SYNC_POL : ~SYNC_POL;
        end
    end

`ifdef PONG_VT_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_frame_cnt <= '0;
        end else if (w_line_start && (r_y == '0)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign pixel_en    = w_pixel_en;
    assign xpos        = r_x;
    assign ypos        = r_y;
    assign active      = w_active;
    assign line_start  = w_line_start;
    assign frame_start = w_line_start && (r_y == '0);
    assign red         = r_pix.red;
    assign green       = r_pix.green;
    assign blue        = r_pix.blue;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;

endmodule

// File: tb/tb_pong_video_timer.sv
// Self-checking bench: two small-timing instances (different divider, porches and sync polarity)
// checked every clock against an arithmetic model of position versus clocks since reset release.
module tb_pong_video_timer;

    // Instance A: H 4/1/1/1, V 3/1/1/1, CLK_DIV 2, active-low syncs
    localparam int A_HA = 4, A_HFP = 1, A_HS = 1, A_HBP = 1;
    localparam int A_VA = 3, A_VFP = 1, A_VS = 1, A_VBP = 1;
    localparam int A_D  = 2;
    localparam bit A_POL = 1'b0;
    // Instance B: H 5/2/2/1, V 2/1/2/1, CLK_DIV 3, active-high syncs
    localparam int B_HA = 5, B_HFP = 2, B_HS = 2, B_HBP = 1;
    localparam int B_VA = 2, B_VFP = 1, B_VS = 2, B_VBP = 1;
    localparam int B_D  = 3;
    localparam bit B_POL = 1'b1;

    localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [4:0] red_in;
    logic [5:0] green_in;
    logic [4:0] blue_in;

    logic       a_pixel_en, a_active, a_frame_start, a_line_start, a_hsync, a_vsync;
    logic [9:0] a_xpos, a_ypos;
    logic [4:0] a_red, a_blue;
    logic [5:0] a_green;
    logic       b_pixel_en, b_active, b_frame_start, b_line_start, b_hsync, b_vsync;
    logic [9:0] b_xpos, b_ypos;
    logic [4:0] b_red, b_blue;
    logic [5:0] b_green;
`ifdef PONG_VT_FRAME_CNT_EN
    logic [15:0] a_frame_cnt, b_frame_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = -1;
    logic [15:0] col_hist [0:4095];

    always #5 Clock = ~Clock;

    pong_video_timer #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .CLK_DIV(A_D), .SYNC_POL(A_POL)
    ) dut_a (
        .Clock(Clock), .Reset(Reset), .pixel_en(a_pixel_en), .xpos(a_xpos), .ypos(a_ypos),
        .active(a_active), .frame_start(a_frame_start), .line_start(a_line_start),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .red(a_red), .green(a_green), .blue(a_blue), .hsync(a_hsync), .vsync(a_vsync)
`ifdef PONG_VT_FRAME_CNT_EN
        , .frame_cnt(a_frame_cnt)
`endif
    );

    pong_video_timer #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .CLK_DIV(B_D), .SYNC_POL(B_POL)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .pixel_en(b_pixel_en), .xpos(b_xpos), .ypos(b_ypos),
        .active(b_active), .frame_start(b_frame_start), .line_start(b_line_start),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .red(b_red), .green(b_green), .blue(b_blue), .hsync(b_hsync), .vsync(b_vsync)
`ifdef PONG_VT_FRAME_CNT_EN
        , .frame_cnt(b_frame_cnt)
`endif
    );

    // Stage-0 model: {pixel_en, x, y, active, line_start, frame_start} in clock n after release
    function automatic logic [23:0] model_s0(input int n, input int d, input int ht, input int vt,
                                             input int ha, input int va);
        int  lin, x, y;
        logic pe, act, ls, fs;
        if (n < 0) return {1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0};
        lin = (n / d) % (ht * vt);
        x   = lin % ht;
        y   = lin / ht;
        pe  = (n % d) == (d - 1);
        act = (x < ha) && (y < va);
        ls  = pe && (x == 0);
        fs  = ls && (y == 0);
        return {pe, 10'(x), 10'(y), act, ls, fs};
    endfunction

    // Stage-1 model: {colour565, hsync, vsync}, one pixel period behind stage 0
    function automatic logic [17:0] model_s1(input int n, input int d, input int ht, input int vt,
                                             input int ha, input int va, input int hss, input int hsw,
                                             input int vss, input int vsw, input bit pol);
        int k, lin, px, py;
        logic [15:0] col;
        logic hs, vs;
        if (n < 0 || (n / d) == 0) return {16'd0, ~pol, ~pol};
        k   = n / d;
        lin = (k - 1) % (ht * vt);
        px  = lin % ht;
        py  = lin / ht;
        col = ((px < ha) && (py < va)) ? col_hist[k * d - 1] : 16'd0;
        hs  = (px >= hss && px < hss + hsw) ? pol : ~pol;
        vs  = (py >= vss && py < vss + vsw) ? pol : ~pol;
        return {col, hs, vs};
    endfunction

    function automatic logic [15:0] model_fcnt(input int n, input int d, input int tot);
        if (n < d) return 16'd0;
        return 16'(((n - d) / (d * tot)) + 1);
    endfunction

    // Advance one clock, track clocks since release, then drive fresh random colour
    task automatic tick();
        logic [15:0] c;
        @(posedge Clock);
        #1;
        if (Reset) cyc = -1;
        else cyc++;
        c = 16'($urandom);
        {red_in, green_in, blue_in} = c;
        if (cyc >= 0) col_hist[cyc] = c;
    endtask

    task automatic test_reset();
        int first_a, first_b;
        Reset = 1'b1;
        {red_in, green_in, blue_in} = 16'hffff;
        repeat (3) tick();
        checks++;
        if ({a_pixel_en, a_xpos, a_ypos, a_active, a_line_start, a_frame_start} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a_s0 got pe=%b x=%0d y=%0d act=%b ls=%b fs=%b want 0 0 0 1 0 0", a_pixel_en, a_xpos, a_ypos, a_active, a_line_start, a_frame_start);
        end
        checks++;
        if ({a_red, a_green, a_blue, a_hsync, a_vsync} !== {16'd0, ~A_POL, ~A_POL}) begin
            errors++;
            $display("FAIL reset_a_s1 got rgb=%h hs=%b vs=%b want 0000 %b %b", {a_red, a_green, a_blue}, a_hsync, a_vsync, ~A_POL, ~A_POL);
        end
        checks++;
        if ({b_pixel_en, b_xpos, b_ypos, b_active, b_line_start, b_frame_start} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b_s0 got pe=%b x=%0d y=%0d act=%b ls=%b fs=%b want 0 0 0 1 0 0", b_pixel_en, b_xpos, b_ypos, b_active, b_line_start, b_frame_start);
        end
        checks++;
        if ({b_red, b_green, b_blue, b_hsync, b_vsync} !== {16'd0, ~B_POL, ~B_POL}) begin
            errors++;
            $display("FAIL reset_b_s1 got rgb=%h hs=%b vs=%b want 0000 %b %b", {b_red, b_green, b_blue}, b_hsync, b_vsync, ~B_POL, ~B_POL);
        end
        // Release and time the first pixel enable of each instance
        Reset   = 1'b0;
        first_a = -2;
        first_b = -2;
        for (int i = 0; i < 40 && (first_a < -1 || first_b < -1); i++) begin
            tick();
            if (a_pixel_en === 1'b1 && first_a < -1) first_a = cyc;
            if (b_pixel_en === 1'b1 && first_b < -1) first_b = cyc;
        end
        checks++;
        if (first_a != A_D - 1) begin
            errors++;
            $display("FAIL first_pixel_en_a got clock %0d want %0d", first_a, A_D - 1);
        end
        checks++;
        if (first_b != B_D - 1) begin
            errors++;
            $display("FAIL first_pixel_en_b got clock %0d want %0d", first_b, B_D - 1);
        end
    endtask

    task automatic test_run(input int n_clocks);
        logic [23:0] e0;
        logic [17:0] e1;
        for (int i = 0; i < n_clocks; i++) begin
            tick();
            e0 = model_s0(cyc, A_D, A_HT, A_VT, A_HA, A_VA);
            e1 = model_s1(cyc, A_D, A_HT, A_VT, A_HA, A_VA, A_HA + A_HFP, A_HS, A_VA + A_VFP, A_VS, A_POL);
            checks++;
            if ({a_pixel_en, a_xpos, a_ypos, a_active, a_line_start, a_frame_start} !== e0) begin
                errors++;
                $display("FAIL run_a_s0 clk=%0d got %h want %h", cyc, {a_pixel_en, a_xpos, a_ypos, a_active, a_line_start, a_frame_start}, e0);
            end
            checks++;
            if ({a_red, a_green, a_blue, a_hsync, a_vsync} !== e1) begin
                errors++;
                $display("FAIL run_a_s1 clk=%0d got %h want %h", cyc, {a_red, a_green, a_blue, a_hsync, a_vsync}, e1);
            end
            e0 = model_s0(cyc, B_D, B_HT, B_VT, B_HA, B_VA);
            e1 = model_s1(cyc, B_D, B_HT, B_VT, B_HA, B_VA, B_HA + B_HFP, B_HS, B_VA + B_VFP, B_VS, B_POL);
            checks++;
            if ({b_pixel_en, b_xpos, b_ypos, b_active, b_line_start, b_frame_start} !== e0) begin
                errors++;
                $display("FAIL run_b_s0 clk=%0d got %h want %h", cyc, {b_pixel_en, b_xpos, b_ypos, b_active, b_line_start, b_frame_start}, e0);
            end
            checks++;
            if ({b_red, b_green, b_blue, b_hsync, b_vsync} !== e1) begin
                errors++;
                $display("FAIL run_b_s1 clk=%0d got %h want %h", cyc, {b_red, b_green, b_blue, b_hsync, b_vsync}, e1);
            end
`ifdef PONG_VT_FRAME_CNT_EN
            checks++;
            if (a_frame_cnt !== model_fcnt(cyc, A_D, A_HT * A_VT)) begin
                errors++;
                $display("FAIL frame_cnt_a clk=%0d got %0d want %0d", cyc, a_frame_cnt, model_fcnt(cyc, A_D, A_HT * A_VT));
            end
            checks++;
            if (b_frame_cnt !== model_fcnt(cyc, B_D, B_HT * B_VT)) begin
                errors++;
                $display("FAIL frame_cnt_b clk=%0d got %0d want %0d", cyc, b_frame_cnt, model_fcnt(cyc, B_D, B_HT * B_VT));
            end
`endif
        end
    endtask

    task automatic test_frame_period();
        int a_t0, a_t1, b_t0, b_t1;
        a_t0 = -1; a_t1 = -1; b_t0 = -1; b_t1 = -1;
        for (int i = 0; i < 3 * B_D * B_HT * B_VT && (a_t1 < 0 || b_t1 < 0); i++) begin
            tick();
            if (a_frame_start === 1'b1) begin
                if (a_t0 < 0) a_t0 = cyc;
                else if (a_t1 < 0) a_t1 = cyc;
            end
            if (b_frame_start === 1'b1) begin
                if (b_t0 < 0) b_t0 = cyc;
                else if (b_t1 < 0) b_t1 = cyc;
            end
        end
        checks++;
        if (a_t1 < 0 || (a_t1 - a_t0) != A_D * A_HT * A_VT) begin
            errors++;
            $display("FAIL frame_period_a got %0d clocks (t0=%0d t1=%0d) want %0d", a_t1 - a_t0, a_t0, a_t1, A_D * A_HT * A_VT);
        end
        checks++;
        if (b_t1 < 0 || (b_t1 - b_t0) != B_D * B_HT * B_VT) begin
            errors++;
            $display("FAIL frame_period_b got %0d clocks (t0=%0d t1=%0d) want %0d", b_t1 - b_t0, b_t0, b_t1, B_D * B_HT * B_VT);
        end
    endtask

    task automatic test_mid_reset();
        test_run($urandom_range(40, 120));
        Reset = 1'b1;
        tick();
        checks++;
        if ({a_pixel_en, a_xpos, a_ypos, a_line_start, a_frame_start, a_red, a_green, a_blue, a_hsync, a_vsync} !== {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'd0, ~A_POL, ~A_POL}) begin
            errors++;
            $display("FAIL mid_reset_a got pe=%b x=%0d y=%0d rgb=%h hs=%b vs=%b want all idle", a_pixel_en, a_xpos, a_ypos, {a_red, a_green, a_blue}, a_hsync, a_vsync);
        end
        checks++;
        if ({b_pixel_en, b_xpos, b_ypos, b_line_start, b_frame_start, b_red, b_green, b_blue, b_hsync, b_vsync} !== {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'd0, ~B_POL, ~B_POL}) begin
            errors++;
            $display("FAIL mid_reset_b got pe=%b x=%0d y=%0d rgb=%h hs=%b vs=%b want all idle", b_pixel_en, b_xpos, b_ypos, {b_red, b_green, b_blue}, b_hsync, b_vsync);
        end
        tick();
        Reset = 1'b0;
        test_run(2 * B_D * B_HT * B_VT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at clock %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_run(3 * A_D * A_HT * A_VT);
        test_frame_period();
        test_run(100);
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
